// File: rtl/mem_bus_responder_if.sv
// Processor <-> memory responder bus: command, byte address and store data
// toward the responder; accept tag plus returning load tag/data back.
// Ports: master = processor side, slave = memory responder side.
interface mem_bus_responder_if #(
    parameter int XLEN = 32
);
    logic [1:0]      proc2mem_command;   // 0 none, 1 load, 2 store, 3 behaves as none
    logic [XLEN-1:0] proc2mem_addr;      // byte address
    logic [63:0]     proc2mem_data;      // store data
    logic [3:0]      mem2proc_response;  // tag of the accepted command, 0 = not accepted
    logic [63:0]     mem2proc_data;      // returning load data, 0 when nothing returns
    logic [3:0]      mem2proc_tag;       // tag of the returning load, 0 when nothing returns

    modport master (
        output proc2mem_command,
        output proc2mem_addr,
        output proc2mem_data,
        input  mem2proc_response,
        input  mem2proc_data,
        input  mem2proc_tag
    );

    modport slave (
        input  proc2mem_command,
        input  proc2mem_addr,
        input  proc2mem_data,
        output mem2proc_response,
        output mem2proc_data,
        output mem2proc_tag
    );
endinterface

// File: rtl/mem_bus_responder.sv
// Purpose: fixed-latency 64-bit memory model answering loads/stores with 4-bit tags.
// Latency: accept tag is combinational; a load accepted in cycle T returns in T+LATENCY.
// Backpressure: load rejected (response 0) when QUEUE_DEPTH loads are pending and none returns.
//
// Ports: clock, reset (synchronous, active low), bus (mem_bus_responder_if.slave).
// Optional feature: define MEM_RESP_STALL_EN to reject every 4th presented command.
// MEM_WORDS must be a power of two >= 2; LATENCY 1..15; QUEUE_DEPTH 1..8.
module mem_bus_responder #(
    parameter int LATENCY     = 4,
    parameter int QUEUE_DEPTH = 4,
    parameter int MEM_WORDS   = 256
) (
    input  logic               clock,
    input  logic               reset,
    mem_bus_responder_if.slave bus
);
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int OCC_W = $clog2(QUEUE_DEPTH + 1);

    // An entry written at the accepting edge is visible one cycle later, so
    // it must wait LATENCY-1 further cycles before returning.
    localparam logic [3:0]       CNT_INIT = 4'(LATENCY - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QUEUE_DEPTH - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(QUEUE_DEPTH);

    typedef struct packed {
        logic [3:0]  tag;
        logic [63:0] dat;   // word captured at acceptance
        logic [3:0]  cnt;   // cycles left before this entry may return
    } pend_t;

    logic [63:0]      mem  [MEM_WORDS];
    pend_t            pend [QUEUE_DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [OCC_W-1:0] occ;
    logic [3:0]       tag_cnt;

    logic [IDX_W-1:0] word_idx;
    logic             is_load;
    logic             is_store;
    logic             presented;
    logic             stall;
    logic             head_done;
    logic             accept;
    logic             push;
    logic             addr_unused;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Only the word-index bits of the address matter; byte offset and the
    // upper bits are deliberately dropped.
    assign word_idx    = bus.proc2mem_addr[3 +: IDX_W];
    assign addr_unused = ^bus.proc2mem_addr;

    assign is_load   = (bus.proc2mem_command == BUS_LOAD);
    assign is_store  = (bus.proc2mem_command == BUS_STORE);
    assign presented = is_load | is_store;

    // All loads share one latency and enter in order, so only the head can
    // be due and at most one entry returns per cycle.
    assign head_done = (occ != '0) && (pend[head_ptr].cnt == 4'd0);

`ifdef MEM_RESP_STALL_EN
    logic [1:0] stall_cnt;

    // Counts every presented command, accepted or not, so the rejection
    // pattern is one in four regardless of queue state.
    assign stall = (stall_cnt == 2'd3);

    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_cnt <= 2'd0;
        end else if (presented) begin
            stall_cnt <= stall_cnt + 2'd1;
        end
    end
`else
    assign stall = 1'b0;
`endif

    // A full queue can still take a load when the head leaves this cycle:
    // the freed slot is reused at the same edge.
    assign accept = reset && presented && !stall &&
                    (is_store || (occ != OCC_FULL) || head_done);
    assign push   = accept && is_load;

    assign bus.mem2proc_response = accept ? tag_cnt : 4'd0;
    assign bus.mem2proc_tag      = (reset && head_done) ? pend[head_ptr].tag : 4'd0;
    assign bus.mem2proc_data     = (reset && head_done) ? pend[head_ptr].dat : 64'd0;

    // Backing store has no reset so contents survive it.
    always_ff @(posedge clock) begin
        if (accept && is_store) begin
            mem[word_idx] <= bus.proc2mem_data;
        end
    end

    // Entry payload: validity is carried by occ, so stale entries left
    // behind by a reset are simply ignored and later overwritten.
    always_ff @(posedge clock) begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (push && (tail_ptr == PTR_W'(i))) begin
                pend[i] <= '{tag: tag_cnt, dat: mem[word_idx], cnt: CNT_INIT};
            end else if (pend[i].cnt != 4'd0) begin
                pend[i].cnt <= pend[i].cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            occ      <= '0;
            tag_cnt  <= 4'd1;
        end else begin
            if (push) begin
                tail_ptr <= ptr_inc(tail_ptr);
            end
            if (head_done) begin
                head_ptr <= ptr_inc(head_ptr);
            end
            case ({push, head_done})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            // Tag 0 means "nothing", so the counter skips it on wrap.
            if (accept) begin
                tag_cnt <= (tag_cnt == 4'd15) ? 4'd1 : tag_cnt + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: three instances with different latency/depth
// share one stimulus stream; each has its own reference model and monitor.
module tb_mem_bus_responder;
    localparam logic [1:0] C_NONE  = 2'd0;
    localparam logic [1:0] C_LOAD  = 2'd1;
    localparam logic [1:0] C_STORE = 2'd2;
    localparam logic [1:0] C_BAD   = 2'd3;
    localparam int         NI      = 3;

    logic              clock;
    logic              rst_n;
    logic [1:0]        cmd;
    logic [31:0]       addr;
    logic [63:0]       wdat;
    logic              drain_chk;
    int                cyc      = 0;
    int                n_checks = 0;
    int                n_fail   = 0;
    logic [NI-1:0][3:0] resp_w;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, want);
        end
    endtask

    // Constant expectations taken straight from the worked examples; the
    // stall build changes which commands are accepted, so they apply only
    // to the default build.
    task automatic dcheck(input string name, input int g, input logic [3:0] want);
`ifndef MEM_RESP_STALL_EN
        check($sformatf("%s[%0d]", name, g), 64'(resp_w[g]), 64'(want));
`endif
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 4 : (g == 1) ? 8 : 5;
        localparam int QD  = (g == 2) ? 3 : 4;

        typedef struct packed {
            logic [3:0]  tag;
            logic [63:0] dat;
            logic [31:0] due;
        } exp_t;

        mem_bus_responder_if #(.XLEN(32)) bus ();

        exp_t        sb_q[$];       // expected completions, oldest first
        int          due_q[$];      // return cycles of loads still holding a slot
        logic [63:0] m_mem [256];
        int          m_tag = 1;
`ifdef MEM_RESP_STALL_EN
        int          m_seen = 0;
`endif

        assign bus.proc2mem_command = cmd;
        assign bus.proc2mem_addr    = addr;
        assign bus.proc2mem_data    = wdat;
        assign resp_w[g]            = bus.mem2proc_response;

        mem_bus_responder #(
            .LATENCY    (LAT),
            .QUEUE_DEPTH(QD),
            .MEM_WORDS  (256)
        ) u_dut (
            .clock(clock),
            .reset(rst_n),
            .bus  (bus.slave)
        );

        // Reference model: acceptance decided from slot occupancy by cycle
        // number; accepted loads push their expected completion.
        always @(negedge clock) begin
            int         idx;
            int         busy;
            logic       freeing;
            logic       stalled;
            logic       ok;
            logic [3:0] want;
            exp_t       e;
            #1;
            idx = int'(addr >> 3) % 256;
            if (!rst_n) begin
                check($sformatf("resp_reset[%0d]", g), 64'(bus.mem2proc_response), 64'd0);
                due_q.delete();
                sb_q.delete();
                m_tag = 1;
`ifdef MEM_RESP_STALL_EN
                m_seen = 0;
`endif
            end else begin
                while (due_q.size() > 0 && due_q[0] < cyc) void'(due_q.pop_front());
                busy    = due_q.size();
                freeing = (busy > 0) && (due_q[0] == cyc);
                stalled = 1'b0;
`ifdef MEM_RESP_STALL_EN
                if (cmd == C_LOAD || cmd == C_STORE) begin
                    stalled = ((m_seen % 4) == 3);
                    m_seen++;
                end
`endif
                ok = (cmd == C_STORE || (cmd == C_LOAD && (busy < QD || freeing))) && !stalled;
                want = ok ? 4'(m_tag) : 4'd0;
                check($sformatf("resp[%0d]", g), 64'(bus.mem2proc_response), 64'(want));
                if (ok) begin
                    if (cmd == C_STORE) begin
                        m_mem[idx] = wdat;
                    end else begin
                        due_q.push_back(cyc + LAT);
                        e.tag = 4'(m_tag);
                        e.dat = m_mem[idx];
                        e.due = 32'(cyc + LAT);
                        sb_q.push_back(e);
                    end
                    m_tag = (m_tag == 15) ? 1 : m_tag + 1;
                end
            end
        end

        // Completion monitor: the DUT must show the oldest expected load
        // exactly in its due cycle and zeros otherwise.
        always @(negedge clock) begin
            exp_t e;
            #2;
            if (!rst_n) begin
                check($sformatf("tag_reset[%0d]", g), 64'(bus.mem2proc_tag), 64'd0);
                check($sformatf("data_reset[%0d]", g), bus.mem2proc_data, 64'd0);
            end else if (sb_q.size() > 0 && sb_q[0].due == 32'(cyc)) begin
                e = sb_q.pop_front();
                check($sformatf("ret_tag[%0d]", g), 64'(bus.mem2proc_tag), 64'(e.tag));
                check($sformatf("ret_data[%0d]", g), bus.mem2proc_data, e.dat);
            end else begin
                check($sformatf("idle_tag[%0d]", g), 64'(bus.mem2proc_tag), 64'd0);
                check($sformatf("idle_data[%0d]", g), bus.mem2proc_data, 64'd0);
            end
            if (drain_chk) begin
                check($sformatf("drain[%0d]", g), 64'(sb_q.size()), 64'd0);
            end
        end
    end

    task automatic drive(input logic r, input logic [1:0] c, input logic [31:0] a,
                         input logic [63:0] d);
        @(negedge clock);
        rst_n = r;
        cmd   = c;
        addr  = a;
        wdat  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, C_NONE, 32'd0, 64'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [63:0] d;
        logic [1:0]  c;
        int          r;

        rst_n     = 1'b0;
        cmd       = C_NONE;
        addr      = 32'd0;
        wdat      = 64'd0;
        drain_chk = 1'b0;

        // Commands presented during reset must be ignored.
        repeat (3) drive(1'b0, C_LOAD, 32'h8, 64'd0);

        // Store then load the same word.
        drive(1'b1, C_STORE, 32'h08, 64'hDEAD_BEEF_0000_0001);
        #1;
        for (int g = 0; g < NI; g++) dcheck("st_then_ld_store", g, 4'd1);
        drive(1'b1, C_LOAD, 32'h08, 64'd0);
        #1;
        for (int g = 0; g < NI; g++) dcheck("st_then_ld_load", g, 4'd2);
        idle(10);

        // Fill words 0..15 with noisy byte offsets and upper bits.
        for (int i = 0; i < 16; i++) begin
            a       = $urandom;
            a[10:3] = 8'(i);
            d       = {$urandom, $urandom};
            drive(1'b1, C_STORE, a, d);
        end
        idle(10);

        // Reset with an empty queue (memory kept), then back-to-back loads.
        repeat (2) drive(1'b0, C_NONE, 32'd0, 64'd0);
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, C_LOAD, 32'(k * 8), 64'd0);
            #1;
            dcheck("b2b_lat4", 0, 4'(k + 1));
            dcheck("b2b_lat8", 1, (k < 4) ? 4'(k + 1) : (k == 8) ? 4'd5 : 4'd0);
        end
        idle(12);

        // Load followed by an overwrite of the same word.
        drive(1'b1, C_LOAD, 32'h0000_0008, 64'd0);
        drive(1'b1, C_STORE, 32'h0000_000C, 64'h0123_4567_89AB_CDEF);
        idle(10);

        // Reset with three loads in flight.
        for (int k = 0; k < 3; k++) drive(1'b1, C_LOAD, 32'(16 + 8 * k), 64'd0);
        repeat (2) drive(1'b0, C_NONE, 32'd0, 64'd0);
        idle(12);

        // Sixteen accepted commands after reset: tag wraps 15 -> 1.
        for (int k = 1; k <= 16; k++) begin
            drive(1'b1, C_STORE, 32'((k * 8) % 128), {$urandom, $urandom});
            #1;
            for (int g = 0; g < NI; g++) dcheck("tag_wrap", g, (k == 16) ? 4'd1 : 4'(k));
        end
        idle(10);

        // Random traffic over words 0..15 with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 99);
            c = (r < 20) ? C_NONE : (r < 65) ? C_LOAD : (r < 95) ? C_STORE : C_BAD;
            a = $urandom;
            a[10:7] = 4'd0;
            d = {$urandom, $urandom};
            drive(($urandom_range(0, 99) > 1), c, a, d);
        end
        idle(12);

        drive(1'b1, C_NONE, 32'd0, 64'd0);
        drain_chk = 1'b1;
        drive(1'b1, C_NONE, 32'd0, 64'd0);
        drain_chk = 1'b0;
        @(negedge clock);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_bus_responder.md
MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low; the ports are named clock and reset.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- LATENCY, 4: cycles from load acceptance to data return; legal range 1..15.
- QUEUE_DEPTH, 4: maximum outstanding loads; legal range 1..8.
- MEM_WORDS, 256: number of 64-bit words in the backing store; power of two.

REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clock, input, 1: clock.
- reset, input, 1: active-low synchronous reset.
- proc2mem_command, input, 2: BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2; value 3 is treated as BUS_NONE.
- proc2mem_addr, input, XLEN: byte address.
- proc2mem_data, input, 64: store data.
- mem2proc_response, output, 4: tag of the accepted command; 0 = rejected or no command.
- mem2proc_data, output, 64: load return data.
- mem2proc_tag, output, 4: tag of the returning load; 0 = no return this cycle.

Function
REQ-004 The word index SHALL be proc2mem_addr[3 +: log2(MEM_WORDS)]; bits [2:0] and all higher bits SHALL be ignored.
REQ-005 mem2proc_response SHALL be combinational in the cycle a command is presented; the command is accepted exactly when mem2proc_response is nonzero.
REQ-006 The tag counter SHALL start at 1 and SHALL advance by 1 on each accepted command, wrapping from 15 to 1 so that 0 is never issued.
REQ-007 An accepted BUS_STORE SHALL write proc2mem_data at that clock edge, SHALL consume a tag, SHALL NOT occupy a queue slot, and SHALL produce no completion.
REQ-008 An accepted BUS_LOAD SHALL snapshot the addressed word at the accepting edge; a later store to the same word SHALL NOT change the returned data.
REQ-009 An accepted BUS_LOAD SHALL enter the pending queue with a countdown of LATENCY.
REQ-010 A load accepted in cycle T SHALL present mem2proc_tag and mem2proc_data in cycle T+LATENCY for exactly one cycle.
REQ-011 Completions SHALL be returned in acceptance order, at most one per cycle.
REQ-012 When no load returns, mem2proc_tag SHALL be 0 and mem2proc_data SHALL be 0.
REQ-013 A BUS_LOAD SHALL be rejected (response 0) when the queue holds QUEUE_DEPTH loads, unless a load completes in the same cycle; in that case the freed slot SHALL be reused and the new load accepted.
REQ-014 A rejected command SHALL NOT advance the tag counter, write memory, or enter the queue.
REQ-015 BUS_NONE SHALL give response 0 and have no side effects.
REQ-016 Back-to-back loads, one per cycle, SHALL sustain full throughput when QUEUE_DEPTH >= LATENCY.

Reset
REQ-017 While reset=0 at a clock edge, the block SHALL:
- empty the pending queue, discarding in-flight loads;
- set the tag counter to 1;
- clear the stall counter.
REQ-018 During reset, mem2proc_response, mem2proc_tag and mem2proc_data SHALL all be 0.
REQ-019 Memory contents SHALL be preserved across reset.
REQ-020 A reset asserted while loads are pending SHALL suppress their completions; no tag from before reset SHALL appear afterward.

Configuration
REQ-021 With MEM_RESP_STALL_EN defined, the block SHALL keep a 2-bit stall counter that increments on every cycle with a non-BUS_NONE command presented.
REQ-022 With MEM_RESP_STALL_EN defined, the command SHALL be rejected whenever that counter equals 3 before incrementing (every 4th presented command).
REQ-023 Without MEM_RESP_STALL_EN, rejection SHALL occur only on a full queue.

Verification
REQ-024 Store 64'hDEAD_BEEF_0000_0001 to addr 0x08 in cycle 0, then load 0x08 in cycle 1 -> responses 1 then 2; in cycle 1+LATENCY, tag=2 and data=64'hDEAD_BEEF_0000_0001.
REQ-025 Loads to 0x00, 0x08, 0x10, 0x18, 0x20 in consecutive cycles (LATENCY=4, QUEUE_DEPTH=4) -> responses 1..5, all accepted with no stall; tags 1..5 return in order, one per cycle.
REQ-026 LATENCY=8, QUEUE_DEPTH=4, loads every cycle -> the fifth load is rejected (response 0, tag counter unchanged) and is accepted after the first completion frees a slot.
REQ-027 Issue 16 accepted commands -> the 15th gets tag 15 and the 16th gets tag 1; tag 0 never appears.
REQ-028 Load 0x08, then store new data to 0x08 the next cycle -> the returned data is the old value.
REQ-029 Assert reset with 3 loads pending -> no completions appear; the next accepted command gets tag 1.
